accum_lane_ctrl: RTL and testbench

- Parametrised controller for the sparse-row multiply-accumulate datapath.
- Tracks the element count per row and selects adder feedback once the adder pipeline has filled.
- Collects tagged final row sums into LANES result registers and hands off a full frame over a valid/ready handshake.
- Sits between the pipelined adder (accum_in) and the downstream result consumer; generalises the fixed 4-lane, fixed-latency controller.

---
 rtl/accum_lane_ctrl.sv | 160 ++++++++++++++++
 tb/tb_accum_lane_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_lane_ctrl.sv
// accum_lane_ctrl
//   Controller for the sparse-row multiply-accumulate datapath. Counts the
//   elements of the current row, returns the adder output as feedback once
//   the adder pipeline has filled, and gathers tagged final row sums into
//   LANES result registers that are handed off as one frame over a
//   valid/ready handshake.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset
//   element    - incoming matrix element (all-zero = no element this cycle)
//   set_bit    - start of a new row
//   accum_in   - adder output; [DATA_W] = final-sum tag, [DATA_W-1:0] = sum
//   out_ready  - consumer accepts the frame
//   feedback   - value returned to the adder input (combinational)
//   count      - elements accumulated in the current row (saturating)
//   adder_out  - frame of row sums, lane i at [i*DATA_W +: DATA_W]
//   out_valid  - frame valid
//   lane_ptr   - next lane to be written
//   overflow   - sticky: a final sum arrived while the frame was full
module accum_lane_ctrl #(
    parameter int DATA_W  = 24,
    parameter int LANES   = 4,
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_W:0]            element,
    input  logic                       set_bit,
    input  logic [DATA_W:0]            accum_in,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          feedback,
    output logic [CNT_W-1:0]           count,
    output logic [LANES*DATA_W-1:0]    adder_out,
    output logic                       out_valid,
    output logic [$clog2(LANES)-1:0]   lane_ptr,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(LANES);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FB_THRESH = CNT_W'(ADD_LAT);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] lane_q [LANES];

    logic              capture;
    logic [DATA_W-1:0] sum;

    assign capture = accum_in[DATA_W];
    assign sum     = accum_in[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Row element counter; independent of the frame FSM.
    // ------------------------------------------------------------------
    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (element == '0) begin
            count <= '0;
        end else if (set_bit) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    // Final sums and the first ADD_LAT-1 partial sums of a row are not
    // valid accumulator values yet, so the adder gets zero instead.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        feedback = '0;
        if (!set_bit && !capture && (count >= FB_THRESH)) begin
            feedback = sum;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register / next state / outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (capture && (lane_ptr == LAST_LANE)) state_d = FULL;
            FULL: if (out_ready)                          state_d = FILL;
            default:                                      state_d = FILL;
        endcase
    end

    // Lane contents are only exposed while the frame is valid.
    always_comb begin
        out_valid = (state_q == FULL);
        adder_out = '0;
        if (state_q == FULL) begin
            for (int i = 0; i < LANES; i++) begin
                adder_out[i*DATA_W +: DATA_W] = lane_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane registers, write pointer and overflow flag.
    // ------------------------------------------------------------------
    // NOTE: the lane registers are reset explicitly because a reset must
    // discard a partial frame; they are few and flop-based, not a RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lane_ptr <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (capture) begin
                        lane_q[lane_ptr] <= sum;
                        // LANES is a power of two, so the increment wraps
                        // to 0 after the last lane on its own.
                        lane_ptr <= lane_ptr + 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        // Hand-off: a coinciding final sum opens the next
                        // frame in lane 0 rather than being lost.
                        for (int i = 1; i < LANES; i++) begin
                            lane_q[i] <= '0;
                        end
                        lane_q[0] <= capture ? sum : '0;
                        lane_ptr  <= capture ? PTR_W'(1) : '0;
                    end else if (capture) begin
                        overflow <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_lane_ctrl.sv
module tb_accum_lane_ctrl;

    localparam int DATA_W = 24;
    localparam int LANES  = 4;
    localparam int CNT_W  = 5;

    logic                     clock;
    logic                     reset;
    logic [DATA_W:0]          element;
    logic                     set_bit;
    logic [DATA_W:0]          accum_in;
    logic                     out_ready;
    logic [DATA_W-1:0]        feedback;
    logic [CNT_W-1:0]         count;
    logic [LANES*DATA_W-1:0]  adder_out;
    logic                     out_valid;
    logic [1:0]               lane_ptr;
    logic                     overflow;

    int checks   = 0;
    int failures = 0;

    accum_lane_ctrl #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ADD_LAT(3),
        .CNT_W  (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .element  (element),
        .set_bit  (set_bit),
        .accum_in (accum_in),
        .out_ready(out_ready),
        .feedback (feedback),
        .count    (count),
        .adder_out(adder_out),
        .out_valid(out_valid),
        .lane_ptr (lane_ptr),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one tagged final sum for exactly one edge.
    task automatic capture(input logic [DATA_W-1:0] v);
        accum_in = {1'b1, v};
        tick();
        accum_in = '0;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s out_valid actual=%0b required=0", tag, out_valid);
        end
        checks++;
        if (adder_out !== '0) begin
            failures++;
            $display("FAIL %s adder_out actual=%h required=0", tag, adder_out);
        end
        checks++;
        if (lane_ptr !== 2'd0) begin
            failures++;
            $display("FAIL %s lane_ptr actual=%0d required=0", tag, lane_ptr);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL %s overflow actual=%0b required=0", tag, overflow);
        end
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL %s count actual=%0d required=0", tag, count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        check_idle("reset_initial");
        reset = 1'b0;
        tick();
        check_idle("reset_release");
    endtask

    task automatic test_reset_mid_frame();
        capture(24'h000011);
        capture(24'h000022);
        checks++;
        if (lane_ptr !== 2'd2) begin
            failures++;
            $display("FAIL midframe_ptr actual=%0d required=2", lane_ptr);
        end
        #2 reset = 1'b1;   // between edges
        #1;
        check_idle("reset_mid_frame");
        reset = 1'b0;
        tick();
        // Reset in the middle of a full-frame handshake.
        capture(24'h000031);
        capture(24'h000032);
        capture(24'h000033);
        capture(24'h000034);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midhs_valid actual=%0b required=1", out_valid);
        end
        #2 reset = 1'b1;
        #1;
        check_idle("reset_mid_handshake");
        reset = 1'b0;
        tick();
    endtask

    task automatic test_feedback();
        logic [DATA_W-1:0] exp_fb;
        element  = 25'h0000005;
        set_bit  = 1'b0;
        accum_in = 25'h0000ABC;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_fb = (k >= 3) ? 24'h000ABC : 24'h0;
            checks++;
            if (count !== CNT_W'(k)) begin
                failures++;
                $display("FAIL fb_count_%0d actual=%0d required=%0d", k, count, k);
            end
            checks++;
            if (feedback !== exp_fb) begin
                failures++;
                $display("FAIL fb_value_%0d actual=%h required=%h", k, feedback, exp_fb);
            end
        end
        // A tagged final sum never feeds back (checked before any edge).
        accum_in = 25'h1000ABC;
        #1;
        checks++;
        if (feedback !== 24'h0) begin
            failures++;
            $display("FAIL fb_tag_block actual=%h required=0", feedback);
        end
        accum_in = 25'h0000ABC;
        set_bit  = 1'b1;
        #1;
        checks++;
        if (feedback !== 24'h0) begin
            failures++;
            $display("FAIL fb_set_bit actual=%h required=0", feedback);
        end
        tick();
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL fb_set_bit_count actual=%0d required=0", count);
        end
        set_bit = 1'b0;
        tick();
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL fb_restart_count actual=%0d required=1", count);
        end
        element = '0;
        tick();
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL fb_no_element_count actual=%0d required=0", count);
        end
        accum_in = '0;
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        element = 25'h0000005;
        set_bit = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp_cnt = (i < 31) ? CNT_W'(i) : 5'd31;
            checks++;
            if (count !== exp_cnt) begin
                failures++;
                $display("FAIL sat_count_%0d actual=%0d required=%0d", i, count, exp_cnt);
            end
        end
        element = '0;
        tick();
    endtask

    task automatic test_frame_fill();
        logic [LANES*DATA_W-1:0] exp_frame;
        exp_frame = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL fill_valid_early_%0d actual=%0b required=0", i, out_valid);
            end
            capture(DATA_W'(i));
            checks++;
            if (lane_ptr !== 2'(i)) begin
                failures++;
                $display("FAIL fill_ptr_%0d actual=%0d required=%0d", i, lane_ptr, i % 4);
            end
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL fill_valid_hold_%0d actual=%0b required=1", c, out_valid);
            end
            checks++;
            if (adder_out !== exp_frame) begin
                failures++;
                $display("FAIL fill_data_hold_%0d actual=%h required=%h", c, adder_out, exp_frame);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_idle("fill_after_handoff");
    endtask

    task automatic test_overflow();
        logic [LANES*DATA_W-1:0] exp_frame;
        exp_frame = {24'h000040, 24'h000030, 24'h000020, 24'h000010};
        out_ready = 1'b0;
        capture(24'h000010);
        capture(24'h000020);
        capture(24'h000030);
        capture(24'h000040);
        capture(24'h000055);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag actual=%0b required=1", overflow);
        end
        checks++;
        if (adder_out !== exp_frame) begin
            failures++;
            $display("FAIL ovf_data actual=%h required=%h", adder_out, exp_frame);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_valid actual=%0b required=1", out_valid);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_handoff_valid actual=%0b required=0", out_valid);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky actual=%0b required=1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*DATA_W-1:0] exp_frame;
        exp_frame = {24'h00007A, 24'h000079, 24'h000078, 24'h000077};
        out_ready = 1'b0;
        capture(24'h000061);
        capture(24'h000062);
        capture(24'h000063);
        capture(24'h000064);
        // Hand-off and capture on the same edge.
        out_ready = 1'b1;
        capture(24'h000077);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_valid actual=%0b required=0", out_valid);
        end
        checks++;
        if (lane_ptr !== 2'd1) begin
            failures++;
            $display("FAIL b2b_ptr actual=%0d required=1", lane_ptr);
        end
        checks++;
        if (adder_out !== '0) begin
            failures++;
            $display("FAIL b2b_hidden actual=%h required=0", adder_out);
        end
        capture(24'h000078);
        capture(24'h000079);
        capture(24'h00007A);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_frame_valid actual=%0b required=1", out_valid);
        end
        checks++;
        if (adder_out !== exp_frame) begin
            failures++;
            $display("FAIL b2b_frame_data actual=%h required=%h", adder_out, exp_frame);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || adder_out !== '0) begin
            failures++;
            $display("FAIL b2b_final_handoff valid=%0b data=%h required valid=0 data=0",
                     out_valid, adder_out);
        end
    endtask

    initial begin
        reset     = 1'b1;
        element   = '0;
        set_bit   = 1'b0;
        accum_in  = '0;
        out_ready = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_feedback();
        test_saturation();
        test_frame_fill();
        test_overflow();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
